// File: rtl/ps2_pkg.sv
// Shared constants, frame-state encoding and parity helper for the PS/2 keycode receiver.
// Parity checking is enabled by defining PS2_PARITY_CHECK_EN.
package ps2_pkg;

   localparam int unsigned BYTE_W     = 8;
   localparam logic [7:0]  BREAK_CODE = 8'hF0;
   localparam logic [7:0]  EXT_CODE   = 8'hE0;
   localparam logic [7:0]  NO_KEY     = 8'h00;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } frame_state_e;

   // PS/2 uses odd parity over the data byte plus the parity bit.
   function automatic logic odd_parity_ok(input logic [BYTE_W-1:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_keycode_rx_if.sv
// Decoded key bus from the PS/2 receiver to the game control logic.
interface ps2_keycode_rx_if;
   logic [7:0] keycode;
   logic       extended;
   logic       key_event;
   logic       make;
   logic       frame_err;

   modport master (output keycode, extended, key_event, make, frame_err);
   modport slave  (input  keycode, extended, key_event, make, frame_err);
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 line synchronizers, falling-edge detect, 11-bit frame FSM and mid-frame timeout.
// Defining PS2_PARITY_CHECK_EN makes odd parity part of frame validation.
module ps2_frame_rx
   import ps2_pkg::*;
#(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 5000
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_ps2_clk,
   input  logic              i_ps2_data,
   output logic [BYTE_W-1:0] o_byte_c,
   output logic              o_byte_done_c,
   output logic              o_frame_err_c
);

   localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_clk_sync;
   logic [SYNC_STAGES-1:0] r_data_sync;
   logic                   r_clk_prev;
   frame_state_e           r_state;
   logic [2:0]             r_bit_cnt;
   logic [BYTE_W-1:0]      r_shift;
   logic [CNT_W-1:0]       r_to_cnt;
`ifdef PS2_PARITY_CHECK_EN
   logic                   r_parity;
`endif

   logic w_clk_s;
   logic w_data_s;
   logic w_edge;
   logic w_timeout;
   logic w_stop;
   logic w_par_ok;

   assign w_clk_s   = r_clk_sync[SYNC_STAGES-1];
   assign w_data_s  = r_data_sync[SYNC_STAGES-1];
   assign w_edge    = r_clk_prev & ~w_clk_s;
   assign w_timeout = (r_state != IDLE) && !w_edge && (r_to_cnt == CNT_LAST);
   assign w_stop    = w_edge && (r_state == STOP);

`ifdef PS2_PARITY_CHECK_EN
   assign w_par_ok = odd_parity_ok(r_shift, r_parity);
`else
   assign w_par_ok = 1'b1;
`endif

   assign o_byte_c      = r_shift;
   assign o_byte_done_c = w_stop && w_data_s && w_par_ok;
   assign o_frame_err_c = (w_stop && !(w_data_s && w_par_ok)) || w_timeout;

   // Synchronizers idle high so reset never fabricates a falling edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_clk_sync  <= '1;
         r_data_sync <= '1;
         r_clk_prev  <= 1'b1;
         r_state     <= IDLE;
         r_bit_cnt   <= 3'd0;
         r_shift     <= '0;
         r_to_cnt    <= '0;
`ifdef PS2_PARITY_CHECK_EN
         r_parity    <= 1'b0;
`endif
      end else begin
         r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
         r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_ps2_data};
         r_clk_prev  <= w_clk_s;

         if (w_edge || (r_state == IDLE) || w_timeout) r_to_cnt <= '0;
         else                                          r_to_cnt <= r_to_cnt + CNT_W'(1);

         if (w_timeout) begin
            r_state <= IDLE;
         end else if (w_edge) begin
            case (r_state)
               IDLE: begin
                  if (!w_data_s) begin
                     r_state   <= DATA;
                     r_bit_cnt <= 3'd0;
                  end
               end
               DATA: begin
                  r_shift   <= {w_data_s, r_shift[BYTE_W-1:1]};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) r_state <= PARITY;
               end
               PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                  r_parity <= w_data_s;
`endif
                  r_state  <= STOP;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: frame deframing plus break/extended prefix decode of the held key.
// Defining PS2_PARITY_CHECK_EN rejects frames with bad odd parity.
module ps2_keycode_rx
   import ps2_pkg::*;
#(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 5000
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    ps2_clk,
   input  logic                    ps2_data,
   ps2_keycode_rx_if.master        kbd
);

   logic [BYTE_W-1:0] w_byte;
   logic              w_byte_done_c;
   logic              w_frame_err_c;

   logic [BYTE_W-1:0] r_keycode;
   logic              r_extended;
   logic              r_key_event;
   logic              r_make;
   logic              r_frame_err;
   logic              r_break_pend;
   logic              r_ext_pend;

   ps2_frame_rx #(
      .SYNC_STAGES    (SYNC_STAGES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_frame_rx (
      .i_clk         (Clk),
      .i_rst_n       (Reset),
      .i_ps2_clk     (ps2_clk),
      .i_ps2_data    (ps2_data),
      .o_byte_c      (w_byte),
      .o_byte_done_c (w_byte_done_c),
      .o_frame_err_c (w_frame_err_c)
   );

   // Prefix bytes only arm flags; a plain byte is a make unless a break is pending.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_keycode    <= NO_KEY;
         r_extended   <= 1'b0;
         r_key_event  <= 1'b0;
         r_make       <= 1'b0;
         r_frame_err  <= 1'b0;
         r_break_pend <= 1'b0;
         r_ext_pend   <= 1'b0;
      end else begin
         r_key_event <= 1'b0;
         r_frame_err <= w_frame_err_c;
         if (w_byte_done_c) begin
            if (w_byte == BREAK_CODE) begin
               r_break_pend <= 1'b1;
            end else if (w_byte == EXT_CODE) begin
               r_ext_pend <= 1'b1;
            end else if (r_break_pend) begin
               // Releasing a key other than the held one leaves the outputs alone.
               if ((w_byte == r_keycode) && (r_ext_pend == r_extended)) begin
                  r_keycode   <= NO_KEY;
                  r_extended  <= 1'b0;
                  r_key_event <= 1'b1;
                  r_make      <= 1'b0;
               end
               r_break_pend <= 1'b0;
               r_ext_pend   <= 1'b0;
            end else begin
               r_keycode   <= w_byte;
               r_extended  <= r_ext_pend;
               r_key_event <= 1'b1;
               r_make      <= 1'b1;
               r_ext_pend  <= 1'b0;
            end
         end
      end
   end

   assign kbd.keycode   = r_keycode;
   assign kbd.extended  = r_extended;
   assign kbd.key_event = r_key_event;
   assign kbd.make      = r_make;
   assign kbd.frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Self-checking bench for ps2_keycode_rx: directed scenarios plus a randomized scan-code stream
// compared against a key-state model. Expectations follow PS2_PARITY_CHECK_EN when defined.
module tb_ps2_keycode_rx;

   localparam int unsigned TB_TIMEOUT = 5000;
   localparam int          HALF       = 8;
   localparam int          GAP        = 20;
`ifdef PS2_PARITY_CHECK_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       mk;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n;
   logic ps2_clk;
   logic ps2_data;

   int checks   = 0;
   int failures = 0;
   int err_cnt  = 0;
   int both_cnt = 0;
   ev_t obs[$];

   // Key-state model used by the random stream
   logic [7:0] m_code;
   logic       m_ext;
   logic       m_brk;
   logic       m_extp;
   ev_t        exp_q[$];

   ps2_keycode_rx_if bus ();

   ps2_keycode_rx #(
      .SYNC_STAGES    (2),
      .TIMEOUT_CYCLES (TB_TIMEOUT)
   ) dut (
      .Clk      (clk),
      .Reset    (rst_n),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .kbd      (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.key_event === 1'b1) obs.push_back({bus.keycode, bus.extended, bus.make});
      if (bus.frame_err === 1'b1) err_cnt++;
      if (bus.key_event === 1'b1 && bus.frame_err === 1'b1) both_cnt++;
   end

   task automatic send_bit(input logic v);
      @(negedge clk);
      ps2_data = v;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
      logic [10:0] f;
      f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) send_bit(f[i]);
      ps2_data = 1'b1;
      repeat (GAP) @(negedge clk);
   endtask

   // Applies one accepted byte to the model: who is held, and what event that implies.
   function automatic void model_byte(input logic [7:0] b);
      if (b == 8'hF0) m_brk = 1'b1;
      else if (b == 8'hE0) m_extp = 1'b1;
      else if (m_brk) begin
         if (b == m_code && m_extp == m_ext) begin
            exp_q.push_back({8'h00, 1'b0, 1'b0});
            m_code = 8'h00;
            m_ext  = 1'b0;
         end
         m_brk  = 1'b0;
         m_extp = 1'b0;
      end else begin
         exp_q.push_back({b, m_extp, 1'b1});
         m_code = b;
         m_ext  = m_extp;
         m_extp = 1'b0;
      end
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (bus.keycode !== 8'h00) begin failures++; $display("FAIL reset_keycode got=%h exp=00", bus.keycode); end
      checks++; if (bus.extended !== 1'b0) begin failures++; $display("FAIL reset_extended got=%b exp=0", bus.extended); end
      checks++; if (bus.key_event !== 1'b0) begin failures++; $display("FAIL reset_key_event got=%b exp=0", bus.key_event); end
      checks++; if (bus.make !== 1'b0) begin failures++; $display("FAIL reset_make got=%b exp=0", bus.make); end
      checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", bus.frame_err); end
      @(negedge clk); rst_n = 1'b1;
      repeat (5) @(negedge clk);
      obs.delete(); err_cnt = 0;
   endtask

   task automatic test_make();
      send_frame(8'h2C, 1'b0, 11);
      checks++; if (obs.size() !== 1) begin failures++; $display("FAIL make_count got=%0d exp=1", obs.size()); end
      else begin
         checks++; if (obs[0] !== {8'h2C, 1'b0, 1'b1}) begin failures++; $display("FAIL make_event got=%h exp=%h", obs[0], {8'h2C, 1'b0, 1'b1}); end
      end
      checks++; if (bus.keycode !== 8'h2C) begin failures++; $display("FAIL make_keycode got=%h exp=2c", bus.keycode); end
      checks++; if (err_cnt !== 0) begin failures++; $display("FAIL make_err got=%0d exp=0", err_cnt); end
      obs.delete();
   endtask

   task automatic test_break();
      send_frame(8'hF0, 1'b0, 11);
      checks++; if (obs.size() !== 0) begin failures++; $display("FAIL break_prefix_event got=%0d exp=0", obs.size()); end
      checks++; if (bus.keycode !== 8'h2C) begin failures++; $display("FAIL break_prefix_keycode got=%h exp=2c", bus.keycode); end
      send_frame(8'h2C, 1'b0, 11);
      checks++; if (obs.size() !== 1) begin failures++; $display("FAIL break_count got=%0d exp=1", obs.size()); end
      else begin
         checks++; if (obs[0] !== {8'h00, 1'b0, 1'b0}) begin failures++; $display("FAIL break_event got=%h exp=%h", obs[0], {8'h00, 1'b0, 1'b0}); end
      end
      checks++; if (bus.keycode !== 8'h00) begin failures++; $display("FAIL break_keycode got=%h exp=00", bus.keycode); end
      obs.delete();
   endtask

   task automatic test_extended();
      send_frame(8'hE0, 1'b0, 11);
      send_frame(8'h75, 1'b0, 11);
      checks++; if (obs.size() !== 1) begin failures++; $display("FAIL ext_make_count got=%0d exp=1", obs.size()); end
      else begin
         checks++; if (obs[0] !== {8'h75, 1'b1, 1'b1}) begin failures++; $display("FAIL ext_make_event got=%h exp=%h", obs[0], {8'h75, 1'b1, 1'b1}); end
      end
      checks++; if ({bus.keycode, bus.extended} !== {8'h75, 1'b1}) begin failures++; $display("FAIL ext_make_out got=%h/%b exp=75/1", bus.keycode, bus.extended); end
      obs.delete();
      // Plain release of 0x75 must not match the extended key
      send_frame(8'hF0, 1'b0, 11);
      send_frame(8'h75, 1'b0, 11);
      checks++; if (obs.size() !== 0 || bus.keycode !== 8'h75) begin failures++; $display("FAIL ext_wrong_release got=%0d/%h exp=0/75", obs.size(), bus.keycode); end
      send_frame(8'hE0, 1'b0, 11);
      send_frame(8'hF0, 1'b0, 11);
      send_frame(8'h75, 1'b0, 11);
      checks++; if (obs.size() !== 1) begin failures++; $display("FAIL ext_break_count got=%0d exp=1", obs.size()); end
      else begin
         checks++; if (obs[0] !== {8'h00, 1'b0, 1'b0}) begin failures++; $display("FAIL ext_break_event got=%h exp=%h", obs[0], {8'h00, 1'b0, 1'b0}); end
      end
      checks++; if ({bus.keycode, bus.extended} !== {8'h00, 1'b0}) begin failures++; $display("FAIL ext_break_out got=%h/%b exp=00/0", bus.keycode, bus.extended); end
      obs.delete();
   endtask

   task automatic test_parity();
      int e0;
      e0 = err_cnt;
      send_frame(8'h1D, 1'b1, 11);
      if (PAR_EN) begin
         checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL parity_err got=%0d exp=1", err_cnt - e0); end
         checks++; if (obs.size() !== 0 || bus.keycode !== 8'h00) begin failures++; $display("FAIL parity_discard got=%0d/%h exp=0/00", obs.size(), bus.keycode); end
      end else begin
         checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL parity_ignored_err got=%0d exp=0", err_cnt - e0); end
         checks++; if (bus.keycode !== 8'h1D) begin failures++; $display("FAIL parity_ignored_keycode got=%h exp=1d", bus.keycode); end
      end
      send_frame(8'hF0, 1'b0, 11);
      send_frame(8'h1D, 1'b0, 11);
      checks++; if (bus.keycode !== 8'h00) begin failures++; $display("FAIL parity_cleanup got=%h exp=00", bus.keycode); end
      obs.delete();
   endtask

   task automatic test_timeout();
      int e0;
      e0 = err_cnt;
      send_bit(1'b1);
      repeat (GAP) @(negedge clk);
      checks++; if (err_cnt - e0 !== 0 || obs.size() !== 0) begin failures++; $display("FAIL idle_high_edge got=%0d/%0d exp=0/0", err_cnt - e0, obs.size()); end
      send_frame(8'h5A, 1'b0, 5);
      repeat (TB_TIMEOUT - 200) @(negedge clk);
      checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL timeout_early got=%0d exp=0", err_cnt - e0); end
      repeat (300) @(negedge clk);
      checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL timeout_err got=%0d exp=1", err_cnt - e0); end
      checks++; if (obs.size() !== 0 || bus.keycode !== 8'h00) begin failures++; $display("FAIL timeout_state got=%0d/%h exp=0/00", obs.size(), bus.keycode); end
      send_frame(8'h2C, 1'b0, 11);
      checks++; if (obs.size() !== 1 || bus.keycode !== 8'h2C) begin failures++; $display("FAIL timeout_recover got=%0d/%h exp=1/2c", obs.size(), bus.keycode); end
      else begin
         checks++; if (obs[0] !== {8'h2C, 1'b0, 1'b1}) begin failures++; $display("FAIL timeout_recover_event got=%h exp=%h", obs[0], {8'h2C, 1'b0, 1'b1}); end
      end
      obs.delete();
   endtask

   task automatic test_reset_midframe();
      int e0;
      send_frame(8'hF0, 1'b0, 11);
      send_frame(8'h55, 1'b0, 6);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if ({bus.keycode, bus.extended, bus.key_event, bus.make, bus.frame_err} !== 12'h000) begin
         failures++; $display("FAIL midreset_outputs got=%h/%b%b%b%b exp=00/0000", bus.keycode, bus.extended, bus.key_event, bus.make, bus.frame_err);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      obs.delete();
      e0 = err_cnt;
      send_frame(8'h1C, 1'b0, 11);
      checks++; if (obs.size() !== 1) begin failures++; $display("FAIL midreset_count got=%0d exp=1", obs.size()); end
      else begin
         checks++; if (obs[0] !== {8'h1C, 1'b0, 1'b1}) begin failures++; $display("FAIL midreset_event got=%h exp=%h", obs[0], {8'h1C, 1'b0, 1'b1}); end
      end
      checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL midreset_err got=%0d exp=0", err_cnt - e0); end
      obs.delete();
   endtask

   task automatic test_random();
      logic [7:0] pool [5];
      logic [7:0] b;
      bit         bad;
      bit         drop;
      int         e0;
      int         r;
      pool[0] = 8'h1C; pool[1] = 8'h1D; pool[2] = 8'h2C; pool[3] = 8'h75; pool[4] = 8'h6B;
      m_code = 8'h1C; m_ext = 1'b0; m_brk = 1'b0; m_extp = 1'b0;
      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 9);
         if (r < 2) b = 8'hF0;
         else if (r < 4) b = 8'hE0;
         else if (r < 6 && m_code != 8'h00) b = m_code;
         else b = pool[$urandom_range(0, 4)];
         bad  = ($urandom_range(0, 7) == 0);
         drop = bad && PAR_EN;
         exp_q.delete();
         if (!drop) model_byte(b);
         e0 = err_cnt;
         send_frame(b, bad, 11);
         checks++; if (obs.size() !== exp_q.size()) begin
            failures++; $display("FAIL rand_count n=%0d byte=%h got=%0d exp=%0d", n, b, obs.size(), exp_q.size());
         end else if (exp_q.size() == 1) begin
            checks++; if (obs[0] !== exp_q[0]) begin failures++; $display("FAIL rand_event n=%0d byte=%h got=%h exp=%h", n, b, obs[0], exp_q[0]); end
         end
         checks++; if ({bus.keycode, bus.extended} !== {m_code, m_ext}) begin
            failures++; $display("FAIL rand_state n=%0d got=%h/%b exp=%h/%b", n, bus.keycode, bus.extended, m_code, m_ext);
         end
         checks++; if (err_cnt - e0 !== int'(drop)) begin failures++; $display("FAIL rand_err n=%0d got=%0d exp=%0d", n, err_cnt - e0, int'(drop)); end
         obs.delete();
      end
      checks++; if (both_cnt !== 0) begin failures++; $display("FAIL event_err_overlap got=%0d exp=0", both_cnt); end
   endtask

   initial begin
      test_reset();
      test_make();
      test_break();
      test_extended();
      test_parity();
      test_timeout();
      test_reset_midframe();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
